// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: instruction field positions,
// control-flag widths, pcsource encodings and the control unit.
package id_stage_pipe_pkg;

    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int FUNC_HI = 25;
    localparam int FUNC_LO = 20;
    localparam int IMM_HI  = 25;
    localparam int IMM_LO  = 10;
    localparam int RD_LO   = 10;
    localparam int RS_LO   = 5;
    localparam int RT_LO   = 0;
    localparam int JIDX_HI = 25;

    localparam int ALUC_W  = 3;
    localparam int PCSRC_W = 2;

    typedef enum logic [PCSRC_W-1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_REG    = 2'd2,
        PC_JUMP   = 2'd3
    } pcsrc_e;

    typedef enum logic [ALUC_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } aluc_e;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'd0,
        OP_ADDI  = 6'd1,
        OP_ANDI  = 6'd2,
        OP_ORI   = 6'd3,
        OP_LW    = 6'd4,
        OP_SW    = 6'd5,
        OP_BEQ   = 6'd6,
        OP_BNE   = 6'd7,
        OP_J     = 6'd8
    } opcode_e;

    // rt_src marks instructions that read rt, so load-use only checks rt for them
    typedef struct packed {
        logic   wreg;
        logic   m2reg;
        logic   wmem;
        logic   regrt;
        logic   aluimm;
        logic   sext;
        logic   shift;
        logic   rt_src;
        aluc_e  aluc;
        pcsrc_e pcsource;
    } ctrl_t;

    function automatic ctrl_t control_unit(input logic [5:0] op, input logic [5:0] func,
                                           input logic rsrtequ);
        ctrl_t c;
        c          = '0;
        c.aluc     = ALU_ADD;
        c.pcsource = PC_NEXT;
        case (op)
            OP_RTYPE: if (func < 6'd8) begin
                c.wreg   = 1'b1;
                c.rt_src = 1'b1;
                c.aluc   = aluc_e'(func[2:0]);
                c.shift  = (func[2:0] >= 3'd5);
            end
            OP_ADDI: begin c.wreg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1; end
            OP_ANDI: begin c.wreg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.aluc = ALU_AND; end
            OP_ORI:  begin c.wreg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.aluc = ALU_OR; end
            OP_LW: begin
                c.wreg = 1'b1; c.m2reg = 1'b1; c.regrt = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1;
            end
            OP_SW: begin c.wmem = 1'b1; c.aluimm = 1'b1; c.sext = 1'b1; c.rt_src = 1'b1; end
            OP_BEQ: begin
                c.sext = 1'b1; c.rt_src = 1'b1; c.aluc = ALU_SUB;
                c.pcsource = rsrtequ ? PC_BRANCH : PC_NEXT;
            end
            OP_BNE: begin
                c.sext = 1'b1; c.rt_src = 1'b1; c.aluc = ALU_SUB;
                c.pcsource = rsrtequ ? PC_NEXT : PC_BRANCH;
            end
            OP_J: c.pcsource = PC_JUMP;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Register file: two combinational read ports, one write port on the falling
// clock edge so a write-back is visible to reads later in the same cycle.
module regfile_p #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [RW-1:0]   i_ra,
    input  logic [RW-1:0]   i_rb,
    input  logic            i_we,
    input  logic [RW-1:0]   i_wn,
    input  logic [XLEN-1:0] i_wd,
    output logic [XLEN-1:0] o_qa,
    output logic [XLEN-1:0] o_qb
);

    logic [XLEN-1:0] r_mem [NREG];

    always_ff @(negedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (i_we && (i_wn != '0)) begin
            r_mem[i_wn] <= i_wd;
        end
    end

    assign o_qa = (i_ra == '0) ? '0 : r_mem[i_ra];
    assign o_qb = (i_rb == '0) ? '0 : r_mem[i_rb];

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: operand forwarding, load-use interlock, branch
// resolution in ID and the ID/EX pipeline register.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_pc4,
    input  logic [31:0]       if_inst,
    output logic              id_ready,
    input  logic              ex_ready,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic [RW-1:0]     ex_rn,
    input  logic [XLEN-1:0]   ex_res,
    input  logic              mem_wreg,
    input  logic [RW-1:0]     mem_rn,
    input  logic [XLEN-1:0]   mem_res,
    input  logic              wb_wreg,
    input  logic [RW-1:0]     wb_rn,
    input  logic [XLEN-1:0]   wb_data,
    output logic              br_taken,
    output logic [XLEN-1:0]   br_target,
    output logic              de_valid,
    output logic [XLEN-1:0]   de_a,
    output logic [XLEN-1:0]   de_b,
    output logic [XLEN-1:0]   de_imm,
    output logic [RW-1:0]     de_rn,
    output logic              de_wreg,
    output logic              de_m2reg,
    output logic              de_wmem,
    output logic              de_aluimm,
    output logic              de_shift,
    output logic [ALUC_W-1:0] de_aluc
);

    logic [5:0]      w_op;
    logic [5:0]      w_func;
    logic [RW-1:0]   w_rs;
    logic [RW-1:0]   w_rt;
    logic [RW-1:0]   w_rd;
    logic [15:0]     w_imm16;
    logic [XLEN-1:0] w_qa;
    logic [XLEN-1:0] w_qb;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_imm;
    logic [RW-1:0]   w_rn;
    ctrl_t           w_ctrl;
    logic            w_stall;
    logic            w_accept;

    assign w_op    = if_inst[OP_HI:OP_LO];
    assign w_func  = if_inst[FUNC_HI:FUNC_LO];
    assign w_rs    = if_inst[RS_LO +: RW];
    assign w_rt    = if_inst[RT_LO +: RW];
    assign w_rd    = if_inst[RD_LO +: RW];
    assign w_imm16 = if_inst[IMM_HI:IMM_LO];

    regfile_p #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk  (clk),
        .clrn (clrn),
        .i_ra (w_rs),
        .i_rb (w_rt),
        .i_we (wb_wreg),
        .i_wn (wb_rn),
        .i_wd (wb_data),
        .o_qa (w_qa),
        .o_qb (w_qb)
    );

    // A load in EX has no data yet, so it is skipped here and caught by the interlock
    assign w_a = (w_rs == '0)                                 ? '0      :
                 (ex_wreg && !ex_m2reg && (ex_rn == w_rs))    ? ex_res  :
                 (mem_wreg && (mem_rn == w_rs))               ? mem_res :
                 (wb_wreg && (wb_rn == w_rs))                 ? wb_data : w_qa;
    assign w_b = (w_rt == '0)                                 ? '0      :
                 (ex_wreg && !ex_m2reg && (ex_rn == w_rt))    ? ex_res  :
                 (mem_wreg && (mem_rn == w_rt))               ? mem_res :
                 (wb_wreg && (wb_rn == w_rt))                 ? wb_data : w_qb;

    assign w_ctrl = control_unit(w_op, w_func, (w_a == w_b));
    assign w_imm  = w_ctrl.sext ? {{(XLEN-16){w_imm16[15]}}, w_imm16}
                                : {{(XLEN-16){1'b0}}, w_imm16};
    assign w_rn   = w_ctrl.regrt ? w_rt : w_rd;

    // Reset masks the interlock so the stage reports ready=ex_ready while held
    assign w_stall  = clrn & if_valid & ex_wreg & ex_m2reg & (ex_rn != '0) &
                      ((ex_rn == w_rs) | (w_ctrl.rt_src & (ex_rn == w_rt)));
    assign id_ready = ex_ready & ~w_stall;
    assign w_accept = if_valid & id_ready;

    // Redirect only when the branch itself is accepted, so IF never skips past it
    assign br_taken  = w_accept & ((w_ctrl.pcsource == PC_BRANCH) | (w_ctrl.pcsource == PC_JUMP));
    assign br_target = (w_ctrl.pcsource == PC_JUMP)
                       ? {if_pc4[XLEN-1:28], if_inst[JIDX_HI:0], 2'b00}
                       : if_pc4 + (w_imm << 2);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            de_valid  <= 1'b0;
            de_a      <= '0;
            de_b      <= '0;
            de_imm    <= '0;
            de_rn     <= '0;
            de_wreg   <= 1'b0;
            de_m2reg  <= 1'b0;
            de_wmem   <= 1'b0;
            de_aluimm <= 1'b0;
            de_shift  <= 1'b0;
            de_aluc   <= '0;
        end else if (ex_ready) begin
            if (w_accept) begin
                de_valid  <= 1'b1;
                de_a      <= w_a;
                de_b      <= w_b;
                de_imm    <= w_imm;
                de_rn     <= w_rn;
                de_wreg   <= w_ctrl.wreg;
                de_m2reg  <= w_ctrl.m2reg;
                de_wmem   <= w_ctrl.wmem;
                de_aluimm <= w_ctrl.aluimm;
                de_shift  <= w_ctrl.shift;
                de_aluc   <= w_ctrl.aluc;
            end else begin
                de_valid  <= 1'b0;
                de_wreg   <= 1'b0;
                de_m2reg  <= 1'b0;
                de_wmem   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed literal cases, a 64-bit/16-register
// instance, then randomized traffic against a behavioural model.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn;
    logic        if_valid;
    logic [31:0] if_pc4, if_inst;
    logic        id_ready;
    logic        ex_ready, ex_wreg, ex_m2reg;
    logic [4:0]  ex_rn;
    logic [31:0] ex_res;
    logic        mem_wreg;
    logic [4:0]  mem_rn;
    logic [31:0] mem_res;
    logic        wb_wreg;
    logic [4:0]  wb_rn;
    logic [31:0] wb_data;
    logic        br_taken;
    logic [31:0] br_target;
    logic        de_valid;
    logic [31:0] de_a, de_b, de_imm;
    logic [4:0]  de_rn;
    logic        de_wreg, de_m2reg, de_wmem, de_aluimm, de_shift;
    logic [2:0]  de_aluc;

    logic        s_if_valid;
    logic [63:0] s_if_pc4;
    logic [31:0] s_if_inst;
    logic        s_id_ready;
    logic        s_ex_ready, s_ex_wreg, s_ex_m2reg;
    logic [3:0]  s_ex_rn;
    logic [63:0] s_ex_res;
    logic        s_mem_wreg;
    logic [3:0]  s_mem_rn;
    logic [63:0] s_mem_res;
    logic        s_wb_wreg;
    logic [3:0]  s_wb_rn;
    logic [63:0] s_wb_data;
    logic        s_br_taken;
    logic [63:0] s_br_target;
    logic        s_de_valid;
    logic [63:0] s_de_a, s_de_b, s_de_imm;
    logic [3:0]  s_de_rn;
    logic        s_de_wreg, s_de_m2reg, s_de_wmem, s_de_aluimm, s_de_shift;
    logic [2:0]  s_de_aluc;

    id_stage_pipe u_dut (
        .clk(clk), .clrn(clrn), .if_valid(if_valid), .if_pc4(if_pc4), .if_inst(if_inst),
        .id_ready(id_ready), .ex_ready(ex_ready), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .ex_rn(ex_rn), .ex_res(ex_res), .mem_wreg(mem_wreg), .mem_rn(mem_rn), .mem_res(mem_res),
        .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data), .br_taken(br_taken),
        .br_target(br_target), .de_valid(de_valid), .de_a(de_a), .de_b(de_b), .de_imm(de_imm),
        .de_rn(de_rn), .de_wreg(de_wreg), .de_m2reg(de_m2reg), .de_wmem(de_wmem),
        .de_aluimm(de_aluimm), .de_shift(de_shift), .de_aluc(de_aluc)
    );

    id_stage_pipe #(.XLEN(64), .NREG(16)) u_dut64 (
        .clk(clk), .clrn(clrn), .if_valid(s_if_valid), .if_pc4(s_if_pc4), .if_inst(s_if_inst),
        .id_ready(s_id_ready), .ex_ready(s_ex_ready), .ex_wreg(s_ex_wreg), .ex_m2reg(s_ex_m2reg),
        .ex_rn(s_ex_rn), .ex_res(s_ex_res), .mem_wreg(s_mem_wreg), .mem_rn(s_mem_rn),
        .mem_res(s_mem_res), .wb_wreg(s_wb_wreg), .wb_rn(s_wb_rn), .wb_data(s_wb_data),
        .br_taken(s_br_taken), .br_target(s_br_target), .de_valid(s_de_valid), .de_a(s_de_a),
        .de_b(s_de_b), .de_imm(s_de_imm), .de_rn(s_de_rn), .de_wreg(s_de_wreg),
        .de_m2reg(s_de_m2reg), .de_wmem(s_de_wmem), .de_aluimm(s_de_aluimm),
        .de_shift(s_de_shift), .de_aluc(s_de_aluc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, fn, 5'd0, rd, rs, rt};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm,
                                         input logic [4:0] rs, input logic [4:0] rt);
        return {op, imm, rs, rt};
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_rf [32];
    logic        d_wreg, d_m2reg, d_wmem, d_regrt, d_aluimm, d_sext, d_shift, d_rtsrc;
    logic        d_beq, d_bne, d_jmp;
    logic [2:0]  d_aluc;
    logic [4:0]  m_rs, m_rt, m_rd, m_rn;
    logic [31:0] m_a, m_b, m_imm, m_target;
    logic        m_stall, m_ready, m_taken;
    logic        e_valid, e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift;
    logic [31:0] e_a, e_b, e_imm;
    logic [4:0]  e_rn;
    logic [2:0]  e_aluc;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        e_valid = 0; e_wreg = 0; e_m2reg = 0; e_wmem = 0; e_aluimm = 0; e_shift = 0;
        e_a = '0; e_b = '0; e_imm = '0; e_rn = '0; e_aluc = '0;
    endtask

    task automatic m_decode(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] fn;
        op = inst[31:26];
        fn = inst[25:20];
        {d_wreg, d_m2reg, d_wmem, d_regrt, d_aluimm, d_sext, d_shift, d_rtsrc} = '0;
        {d_beq, d_bne, d_jmp} = '0;
        d_aluc = 3'd0;
        case (op)
            6'd0: if (fn < 6'd8) begin
                d_wreg = 1; d_rtsrc = 1; d_aluc = fn[2:0]; d_shift = (fn >= 6'd5);
            end
            6'd1: begin d_wreg = 1; d_regrt = 1; d_aluimm = 1; d_sext = 1; end
            6'd2: begin d_wreg = 1; d_regrt = 1; d_aluimm = 1; d_aluc = 3'd2; end
            6'd3: begin d_wreg = 1; d_regrt = 1; d_aluimm = 1; d_aluc = 3'd3; end
            6'd4: begin d_wreg = 1; d_m2reg = 1; d_regrt = 1; d_aluimm = 1; d_sext = 1; end
            6'd5: begin d_wmem = 1; d_aluimm = 1; d_sext = 1; d_rtsrc = 1; end
            6'd6: begin d_sext = 1; d_rtsrc = 1; d_beq = 1; d_aluc = 3'd1; end
            6'd7: begin d_sext = 1; d_rtsrc = 1; d_bne = 1; d_aluc = 3'd1; end
            6'd8: d_jmp = 1;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] m_opnd(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (ex_wreg && !ex_m2reg && ex_rn == r) return ex_res;
        if (mem_wreg && mem_rn == r) return mem_res;
        if (wb_wreg && wb_rn == r) return wb_data;
        return m_rf[r];
    endfunction

    task automatic m_eval();
        m_decode(if_inst);
        m_rs  = if_inst[9:5];
        m_rt  = if_inst[4:0];
        m_rd  = if_inst[14:10];
        m_a   = m_opnd(m_rs);
        m_b   = m_opnd(m_rt);
        m_imm = d_sext ? 32'($signed(if_inst[25:10])) : 32'(if_inst[25:10]);
        m_rn  = d_regrt ? m_rt : m_rd;
        m_stall = clrn && if_valid && ex_wreg && ex_m2reg && ex_rn != 0 &&
                  (ex_rn == m_rs || (d_rtsrc && ex_rn == m_rt));
        m_ready = ex_ready && !m_stall;
        m_taken = if_valid && m_ready &&
                  (d_jmp || (d_beq && m_a == m_b) || (d_bne && m_a != m_b));
        m_target = d_jmp ? {if_pc4[31:28], if_inst[25:0], 2'b00} : if_pc4 + m_imm * 4;
    endtask

    task automatic m_clock();
        if (!clrn) begin
            m_reset();
        end else begin
            if (ex_ready) begin
                if (if_valid && m_ready) begin
                    e_valid = 1; e_a = m_a; e_b = m_b; e_imm = m_imm; e_rn = m_rn;
                    e_wreg = d_wreg; e_m2reg = d_m2reg; e_wmem = d_wmem;
                    e_aluimm = d_aluimm; e_shift = d_shift; e_aluc = d_aluc;
                end else begin
                    e_valid = 0; e_wreg = 0; e_m2reg = 0; e_wmem = 0;
                end
            end
            if (wb_wreg && wb_rn != 0) m_rf[wb_rn] = wb_data;
        end
    endtask

    task automatic check_regs();
        chk("de_valid", de_valid, e_valid);
        chk("de_wreg", de_wreg, e_wreg);
        chk("de_m2reg", de_m2reg, e_m2reg);
        chk("de_wmem", de_wmem, e_wmem);
        if (e_valid) begin
            chk("de_a", de_a, e_a);
            chk("de_b", de_b, e_b);
            chk("de_imm", de_imm, e_imm);
            chk("de_rn", de_rn, e_rn);
            chk("de_aluimm", de_aluimm, e_aluimm);
            chk("de_shift", de_shift, e_shift);
            chk("de_aluc", de_aluc, e_aluc);
        end
    endtask

    task automatic idle();
        if_valid = 0; if_pc4 = '0; if_inst = '0; ex_ready = 1;
        ex_wreg = 0; ex_m2reg = 0; ex_rn = '0; ex_res = '0;
        mem_wreg = 0; mem_rn = '0; mem_res = '0;
        wb_wreg = 0; wb_rn = '0; wb_data = '0;
    endtask

    task automatic s_idle();
        s_if_valid = 0; s_if_pc4 = '0; s_if_inst = '0; s_ex_ready = 1;
        s_ex_wreg = 0; s_ex_m2reg = 0; s_ex_rn = '0; s_ex_res = '0;
        s_mem_wreg = 0; s_mem_rn = '0; s_mem_res = '0;
        s_wb_wreg = 0; s_wb_rn = '0; s_wb_data = '0;
    endtask

    task automatic randomize_inputs();
        logic [5:0] op;
        logic [31:0] inst;
        int r;
        r  = $urandom_range(0, 9);
        op = (r == 9) ? 6'd12 : 6'(r);
        inst = $urandom;
        inst[31:26] = op;
        inst[9:5]   = 5'($urandom_range(0, 7));
        inst[4:0]   = 5'($urandom_range(0, 7));
        inst[14:10] = 5'($urandom_range(0, 7));
        if (op == 6'd0) inst[25:20] = 6'($urandom_range(0, 9));
        if_inst  = inst;
        if_valid = ($urandom_range(0, 9) < 8);
        if_pc4   = $urandom;
        ex_ready = ($urandom_range(0, 9) < 8);
        ex_wreg  = 1'($urandom_range(0, 1));
        ex_m2reg = ($urandom_range(0, 2) == 0);
        ex_rn    = 5'($urandom_range(0, 7));
        ex_res   = $urandom;
        mem_wreg = 1'($urandom_range(0, 1));
        mem_rn   = 5'($urandom_range(0, 7));
        mem_res  = $urandom;
        wb_wreg  = 1'($urandom_range(0, 1));
        wb_rn    = 5'($urandom_range(0, 7));
        wb_data  = $urandom;
    endtask

    initial begin
        clrn = 1'b0;
        idle();
        s_idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_de_valid", de_valid, 1'b0);
        chk("rst_id_ready", id_ready, 1'b1);
        ex_ready = 0;
        #1;
        chk("rst_id_ready_bp", id_ready, 1'b0);
        ex_ready = 1;

        // 64-bit / 16-register instance: jump keeps pc4 upper bits
        @(posedge clk); #1;
        clrn = 1'b1;
        s_if_valid = 1;
        s_if_pc4   = 64'h1234_5678_9ABC_DEF0;
        s_if_inst  = {6'd8, 26'h0ABCDEF};
        #6;
        chk("w64_jump_taken", s_br_taken, 1'b1);
        chk("w64_jump_target", s_br_target, 64'h1234_5678_92AF_37BC);
        @(posedge clk); #1;
        s_if_inst = {6'd1, 16'h8001, 5'd0, 5'b10011};
        @(posedge clk); #1;
        chk("w64_sext_imm", s_de_imm, 64'hFFFF_FFFF_FFFF_8001);
        chk("w64_rt_lowbits", s_de_rn, 4'd3);
        chk("w64_valid", s_de_valid, 1'b1);
        s_idle();

        // EX beats MEM for the same register, MEM used once EX drops out
        if_valid = 1;
        if_inst  = mk_r(6'd0, 5'd7, 5'd5, 5'd6);
        ex_wreg = 1; ex_rn = 5'd5; ex_res = 32'h11;
        mem_wreg = 1; mem_rn = 5'd5; mem_res = 32'h22;
        @(posedge clk); #1;
        chk("fwd_ex", de_a, 32'h11);
        chk("rf_zero_after_rst", de_b, 32'h0);
        chk("fwd_rn", de_rn, 5'd7);
        chk("fwd_valid", de_valid, 1'b1);
        ex_wreg = 0;
        @(posedge clk); #1;
        chk("fwd_mem", de_a, 32'h22);

        // load-use: one stall cycle, one bubble, then issue with MEM forwarding
        mem_wreg = 0;
        if_inst  = mk_r(6'd0, 5'd8, 5'd3, 5'd4);
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 5'd3;
        #6;
        chk("lu_id_ready", id_ready, 1'b0);
        @(posedge clk); #1;
        chk("lu_bubble", de_valid, 1'b0);
        chk("lu_bubble_wreg", de_wreg, 1'b0);
        ex_wreg = 0; ex_m2reg = 0;
        mem_wreg = 1; mem_rn = 5'd3; mem_res = 32'h55;
        #6;
        chk("lu_ready_again", id_ready, 1'b1);
        @(posedge clk); #1;
        chk("lu_issue", de_valid, 1'b1);
        chk("lu_fwd", de_a, 32'h55);

        // beq with equal forwarded operands, then unequal
        if_pc4  = 32'h100;
        if_inst = mk_i(6'd6, 16'hFFFE, 5'd1, 5'd2);
        ex_wreg = 1; ex_rn = 5'd1; ex_res = 32'h33;
        mem_wreg = 1; mem_rn = 5'd2; mem_res = 32'h33;
        #6;
        chk("br_taken_eq", br_taken, 1'b1);
        chk("br_target", br_target, 32'hF8);
        mem_res = 32'h34;
        #1;
        chk("br_taken_ne", br_taken, 1'b0);

        // backpressure holds ID/EX; WB to r0 is ignored
        @(posedge clk); #1;
        ex_wreg = 0; mem_wreg = 0;
        if_inst = mk_i(6'd1, 16'h1234, 5'd0, 5'd9);
        @(posedge clk); #1;
        chk("bp_capture_imm", de_imm, 32'h1234);
        ex_ready = 0;
        wb_wreg = 1; wb_rn = 5'd0; wb_data = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            if_inst = $urandom;
            #6;
            chk("bp_id_ready", id_ready, 1'b0);
            @(posedge clk); #1;
            chk("bp_hold_imm", de_imm, 32'h1234);
            chk("bp_hold_rn", de_rn, 5'd9);
            chk("bp_hold_valid", de_valid, 1'b1);
        end
        ex_ready = 1; wb_wreg = 0;
        if_inst = mk_r(6'd0, 5'd1, 5'd0, 5'd0);
        @(posedge clk); #1;
        chk("r0_reads_zero", de_a, 32'h0);

        // randomized traffic against the model, with occasional resets
        clrn = 1'b0;
        idle();
        m_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            check_regs();
            if (!clrn) begin
                clrn = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                clrn = 1'b0;
                m_reset();
                #1;
                chk("async_rst_valid", de_valid, 1'b0);
            end
            randomize_inputs();
            #6;
            m_eval();
            chk("id_ready", id_ready, m_ready);
            chk("br_taken", br_taken, m_taken);
            if (m_taken) chk("br_target", br_target, m_target);
            m_clock();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
